// File: rtl/decode_issue_stage_if.sv
// Control-word types shared by the decode/issue stage and its ID/EX bus,
// plus the interface bundling the fetch-side and EX-side handshakes.
package decode_issue_pkg;
  typedef enum logic {alumux1_rs1_out = 1'b0, alumux1_pc_out = 1'b1} alumux1_sel_t;
  typedef enum logic [2:0] {
    alumux2_i_imm = 3'd0, alumux2_u_imm = 3'd1, alumux2_b_imm = 3'd2,
    alumux2_s_imm = 3'd3, alumux2_j_imm = 3'd4, alumux2_rs2_out = 3'd5
  } alumux2_sel_t;
  typedef enum logic {cmpmux_rs2_out = 1'b0, cmpmux_i_imm = 1'b1} cmpmux_sel_t;
  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;
  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;
  typedef enum logic [3:0] {
    rfm_alu_out = 4'd0, rfm_br_en = 4'd1, rfm_u_imm = 4'd2, rfm_lw = 4'd3,
    rfm_pc_plus4 = 4'd4, rfm_lb = 4'd5, rfm_lbu = 4'd6, rfm_lh = 4'd7, rfm_lhu = 4'd8
  } regfilemux_sel_t;

  typedef struct packed {
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            dcache_read;
    logic            dcache_write;
    regfilemux_sel_t regfilemux_sel;
    logic            load_regfile;
  } ctrl_word;

  localparam ctrl_word CTRL_DEFAULT = '{
    alumux1_sel: alumux1_rs1_out, alumux2_sel: alumux2_i_imm, cmpmux_sel: cmpmux_i_imm,
    aluop: alu_add, cmpop: blt, dcache_read: 1'b0, dcache_write: 1'b0,
    regfilemux_sel: rfm_alu_out, load_regfile: 1'b0
  };

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
endpackage

interface decode_issue_stage_if;
  import decode_issue_pkg::*;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  ctrl_word    ex_ctrl;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_muldiv;
  logic [2:0]  ex_muldiv_op;
  logic        ex_illegal;

  modport slave (
    input  id_valid, id_instr, id_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_ctrl, ex_pc, ex_rs1, ex_rs2, ex_rd,
           ex_muldiv, ex_muldiv_op, ex_illegal
  );
  modport master (
    output id_valid, id_instr, id_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_ctrl, ex_pc, ex_rs1, ex_rs2, ex_rd,
           ex_muldiv, ex_muldiv_op, ex_illegal
  );
endinterface

// File: rtl/decode_issue_stage.sv
// RV32I/M decode into a one-entry ID/EX register with valid/ready on both sides,
// load-use stall, flush, illegal flagging and a multi-cycle hold for M ops.
module decode_issue_stage
  import decode_issue_pkg::*;
#(
  parameter int MULDIV_EN   = 1,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 6
) (
  input logic                 clk,
  input logic                 rst,
  decode_issue_stage_if.slave bus
);

  typedef struct packed {
    ctrl_word   ctrl;
    logic       illegal;
    logic       muldiv;
    logic [2:0] muldiv_op;
    logic       uses_rs2;
  } dec_t;

  localparam logic [CNT_W-1:0] MUL_HOLD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_HOLD = CNT_W'(DIV_LATENCY - 1);

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7          = instr[31:25];
    f3          = instr[14:12];
    d.ctrl      = CTRL_DEFAULT;
    d.illegal   = 1'b0;
    d.muldiv    = 1'b0;
    d.muldiv_op = 3'b000;
    d.uses_rs2  = 1'b0;
    case (instr[6:0])
      OP_LUI: begin
        d.ctrl.regfilemux_sel = rfm_u_imm;
        d.ctrl.load_regfile   = 1'b1;
      end
      OP_AUIPC: begin
        d.ctrl.alumux1_sel  = alumux1_pc_out;
        d.ctrl.alumux2_sel  = alumux2_u_imm;
        d.ctrl.load_regfile = 1'b1;
      end
      OP_JAL: begin
        d.ctrl.alumux1_sel    = alumux1_pc_out;
        d.ctrl.alumux2_sel    = alumux2_j_imm;
        d.ctrl.regfilemux_sel = rfm_pc_plus4;
        d.ctrl.load_regfile   = 1'b1;
      end
      OP_JALR: begin
        d.ctrl.regfilemux_sel = rfm_pc_plus4;
        d.ctrl.load_regfile   = 1'b1;
      end
      OP_BR: begin
        d.ctrl.alumux1_sel = alumux1_pc_out;
        d.ctrl.alumux2_sel = alumux2_b_imm;
        d.ctrl.cmpmux_sel  = cmpmux_rs2_out;
        d.ctrl.cmpop       = branch_funct3_t'(f3);
        d.uses_rs2         = 1'b1;
      end
      OP_LOAD: begin
        d.ctrl.dcache_read  = 1'b1;
        d.ctrl.load_regfile = 1'b1;
        case (f3)
          3'b000:  d.ctrl.regfilemux_sel = rfm_lb;
          3'b001:  d.ctrl.regfilemux_sel = rfm_lh;
          3'b100:  d.ctrl.regfilemux_sel = rfm_lbu;
          3'b101:  d.ctrl.regfilemux_sel = rfm_lhu;
          default: d.ctrl.regfilemux_sel = rfm_lw;
        endcase
      end
      OP_STORE: begin
        d.ctrl.alumux2_sel  = alumux2_s_imm;
        d.ctrl.dcache_write = 1'b1;
        d.uses_rs2          = 1'b1;
      end
      OP_IMM: begin
        d.ctrl.load_regfile = 1'b1;
        case (f3)
          3'b010: begin d.ctrl.cmpop = blt;  d.ctrl.regfilemux_sel = rfm_br_en; end
          3'b011: begin d.ctrl.cmpop = bltu; d.ctrl.regfilemux_sel = rfm_br_en; end
          3'b001: begin
            d.ctrl.aluop = alu_sll;
            d.illegal    = (f7 != 7'b0000000);
          end
          3'b101: begin
            if (f7 == 7'b0000000)      d.ctrl.aluop = alu_srl;
            else if (f7 == 7'b0100000) d.ctrl.aluop = alu_sra;
            else                       d.illegal    = 1'b1;
          end
          default: d.ctrl.aluop = alu_ops'(f3);
        endcase
      end
      OP_REG: begin
        d.ctrl.alumux2_sel  = alumux2_rs2_out;
        d.ctrl.cmpmux_sel   = cmpmux_rs2_out;
        d.ctrl.load_regfile = 1'b1;
        d.uses_rs2          = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b010:  begin d.ctrl.cmpop = blt;  d.ctrl.regfilemux_sel = rfm_br_en; end
            3'b011:  begin d.ctrl.cmpop = bltu; d.ctrl.regfilemux_sel = rfm_br_en; end
            3'b101:  d.ctrl.aluop = alu_srl;
            default: d.ctrl.aluop = alu_ops'(f3);
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.ctrl.aluop = alu_sub;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d.ctrl.aluop = alu_sra;
        end else if (f7 == 7'b0000001 && MULDIV_EN != 0) begin
          d.muldiv    = 1'b1;
          d.muldiv_op = f3;
        end else begin
          d.illegal = 1'b1;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal encodings must never write the register file or touch memory.
    if (d.illegal) begin
      d.ctrl   = CTRL_DEFAULT;
      d.muldiv = 1'b0;
    end
    return d;
  endfunction

  logic             r_vld_p1;
  logic [CNT_W-1:0] r_cnt_p1;
  ctrl_word         r_ctrl_p1;
  logic [31:0]      r_pc_p1;
  logic [4:0]       r_rs1_p1;
  logic [4:0]       r_rs2_p1;
  logic [4:0]       r_rd_p1;
  logic             r_muldiv_p1;
  logic [2:0]       r_mdop_p1;
  logic             r_illegal_p1;

  dec_t       w_dec;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_ex_valid;
  logic       w_ex_fire;
  logic       w_slot_free;
  logic       w_hazard;
  logic       w_id_ready;
  logic       w_accept;

  // Stage 0: combinational decode and handshake
  assign w_dec       = decode(bus.id_instr);
  assign w_rs1       = bus.id_instr[19:15];
  assign w_rs2       = bus.id_instr[24:20];
  assign w_ex_valid  = r_vld_p1 && (r_cnt_p1 == '0);
  assign w_ex_fire   = w_ex_valid && bus.ex_ready;
  assign w_slot_free = !r_vld_p1 || w_ex_fire;
  assign w_hazard    = r_vld_p1 && r_ctrl_p1.dcache_read && (r_rd_p1 != 5'd0) &&
                       ((r_rd_p1 == w_rs1) || (w_dec.uses_rs2 && (r_rd_p1 == w_rs2)));
  assign w_id_ready  = !rst && !bus.flush && w_slot_free && !w_hazard;
  assign w_accept    = bus.id_valid && w_id_ready;

  // Stage 1: ID/EX entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_cnt_p1     <= '0;
      r_ctrl_p1    <= CTRL_DEFAULT;
      r_pc_p1      <= '0;
      r_rs1_p1     <= '0;
      r_rs2_p1     <= '0;
      r_rd_p1      <= '0;
      r_muldiv_p1  <= 1'b0;
      r_mdop_p1    <= '0;
      r_illegal_p1 <= 1'b0;
    end else if (bus.flush) begin
      r_vld_p1 <= 1'b0;
      r_cnt_p1 <= '0;
    end else if (w_accept) begin
      r_vld_p1     <= 1'b1;
      r_cnt_p1     <= w_dec.muldiv ? (w_dec.muldiv_op[2] ? DIV_HOLD : MUL_HOLD) : '0;
      r_ctrl_p1    <= w_dec.ctrl;
      r_pc_p1      <= bus.id_pc;
      r_rs1_p1     <= w_rs1;
      r_rs2_p1     <= w_rs2;
      r_rd_p1      <= bus.id_instr[11:7];
      r_muldiv_p1  <= w_dec.muldiv;
      r_mdop_p1    <= w_dec.muldiv_op;
      r_illegal_p1 <= w_dec.illegal;
    end else begin
      if (w_ex_fire)        r_vld_p1 <= 1'b0;
      if (r_cnt_p1 != '0)   r_cnt_p1 <= r_cnt_p1 - 1'b1;
    end
  end

  assign bus.id_ready     = w_id_ready;
  assign bus.ex_valid     = w_ex_valid;
  assign bus.ex_ctrl      = r_ctrl_p1;
  assign bus.ex_pc        = r_pc_p1;
  assign bus.ex_rs1       = r_rs1_p1;
  assign bus.ex_rs2       = r_rs2_p1;
  assign bus.ex_rd        = r_rd_p1;
  assign bus.ex_muldiv    = r_muldiv_p1;
  assign bus.ex_muldiv_op = r_mdop_p1;
  assign bus.ex_illegal   = r_illegal_p1;

endmodule
